// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: command encodings, latencies, FSM states and flag indices shared by the issue controller
package alu_issue_ctrl_pkg;
    localparam logic [3:0] CMD_ADD     = 4'b0000;
    localparam logic [3:0] CMD_MUL_INC = 4'b1001;
    localparam logic [3:0] CMD_MUL_SHL = 4'b1010;
    localparam logic [3:0] CMD_SADD    = 4'b1011;
    localparam logic [3:0] CMD_SSUB    = 4'b1100;
    localparam logic [1:0] LAT_STD = 2'd2;
    localparam logic [1:0] LAT_MUL = 2'd3;
    localparam int FLAG_COUT  = 5;
    localparam int FLAG_OFLOW = 4;
    localparam int FLAG_G     = 3;
    localparam int FLAG_E     = 2;
    localparam int FLAG_L     = 1;
    localparam int FLAG_ERR   = 0;
    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, HOLD} state_e;
    // arithmetic multiplies need one extra cycle in ALU1
    function automatic logic [1:0] cmd_lat(input logic mode, input logic [3:0] cmd);
        return (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL)) ? LAT_MUL : LAT_STD;
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: circular command buffer between the request port and the issue FSM
module alu_cmd_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_q];
    // pointer/occupancy update; a full buffer refuses writes even when popping in the same cycle
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // pointers flush on reset; storage contents are don't-care once pointers are cleared
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // storage write
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU requests, issues them to ALU1 one at a time and registers the result
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int INPUT = 8,
    parameter int DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [INPUT-1:0]   IN_OPA,
    input  logic [INPUT-1:0]   IN_OPB,
    input  logic               IN_CIN,
    input  logic               IN_MODE,
    input  logic [3:0]         IN_CMD,
    input  logic [1:0]         IN_OPV,
    output logic [INPUT-1:0]   OPA,
    output logic [INPUT-1:0]   OPB,
    output logic               CIN,
    output logic               CE,
    output logic               MODE,
    output logic [3:0]         CMD,
    output logic [1:0]         VALID,
    input  logic [2*INPUT-1:0] ALU_RES,
    input  logic [5:0]         ALU_FLAGS,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [2*INPUT-1:0] OUT_RES,
    output logic [5:0]         OUT_FLAGS,
    output logic               BUSY
);
    localparam int EW = 2*INPUT + 8;
    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [INPUT-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic               cin_q, cin_d, ce_q, ce_d, mode_q, mode_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [1:0]         valid_q, valid_d;
    logic               out_valid_q, out_valid_d;
    logic [2*INPUT-1:0] out_res_q, out_res_d;
    logic [5:0]         out_flags_q, out_flags_d;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [EW-1:0]      fifo_dout;
    logic [INPUT-1:0]   head_opa, head_opb;
    logic               head_cin, head_mode;
    logic [3:0]         head_cmd;
    logic [1:0]         head_opv;
    assign IN_READY = RST && !fifo_full;
    assign BUSY     = !fifo_empty || state_q != IDLE;
    assign {head_opa, head_opb, head_cin, head_mode, head_cmd, head_opv} = fifo_dout;
    assign {OPA, OPB, CIN, CE, MODE, CMD, VALID} = {opa_q, opb_q, cin_q, ce_q, mode_q, cmd_q, valid_q};
    assign {OUT_VALID, OUT_RES, OUT_FLAGS} = {out_valid_q, out_res_q, out_flags_q};
    alu_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (IN_VALID && IN_READY),
        .pop   (fifo_pop),
        .din   ({IN_OPA, IN_OPB, IN_CIN, IN_MODE, IN_CMD, IN_OPV}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    // state and datapath registers; reset abandons any in-flight op
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cin_q       <= 1'b0;
            ce_q        <= 1'b0;
            mode_q      <= 1'b0;
            cmd_q       <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cin_q       <= cin_d;
            ce_q        <= ce_d;
            mode_q      <= mode_d;
            cmd_q       <= cmd_d;
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_flags_q <= out_flags_d;
        end
    end
    // next state: issue when work is queued, wait out the latency, capture, then hold for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fifo_empty ? IDLE : WAIT;
            WAIT:    state_d = (cnt_q == 2'd1) ? CAPTURE : WAIT;
            CAPTURE: state_d = HOLD;
            HOLD:    state_d = OUT_READY ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end
    // outputs: ALU port values persist through HOLD; only CE and VALID return to idle levels
    always_comb begin
        {opa_d, opb_d, cin_d, mode_d, cmd_d, valid_d} = {opa_q, opb_q, cin_q, mode_q, cmd_q, valid_q};
        ce_d        = ce_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_flags_d = out_flags_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    {opa_d, opb_d, cin_d, mode_d, cmd_d, valid_d} = fifo_dout;
                    ce_d  = 1'b1;
                    cnt_d = cmd_lat(head_mode, head_cmd);
                end
            end
            WAIT: cnt_d = cnt_q - 2'd1;
            CAPTURE: begin
                out_res_d   = ALU_RES;
                out_flags_d = ALU_FLAGS;
                out_valid_d = 1'b1;
                ce_d        = 1'b0;
            end
            HOLD: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    valid_d     = 2'b00;
                end
            end
            default: ce_d = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench with a latency-aware ALU1 stand-in
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic        IN_VALID = 1'b0, IN_READY;
    logic [7:0]  IN_OPA = '0, IN_OPB = '0;
    logic        IN_CIN = 1'b0, IN_MODE = 1'b0;
    logic [3:0]  IN_CMD = '0;
    logic [1:0]  IN_OPV = '0;
    logic [7:0]  OPA, OPB;
    logic        CIN, CE, MODE;
    logic [3:0]  CMD;
    logic [1:0]  VALID;
    logic [15:0] ALU_RES;
    logic [5:0]  ALU_FLAGS;
    logic        OUT_VALID, OUT_READY = 1'b1;
    logic [15:0] OUT_RES;
    logic [5:0]  OUT_FLAGS;
    logic        BUSY;
    int checks = 0;
    int failures = 0;
    logic [21:0] exp_q[$];
    int ce_cnt = 0;
    logic [8:0]  sum9, dif9;
    logic [16:0] mres;
    logic [15:0] alu_r;
    logic        cout, ofl;
    int          lat;

    alu_issue_ctrl #(.INPUT(8), .DEPTH(4)) dut (
        .CLK(clk), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_OPA(IN_OPA), .IN_OPB(IN_OPB), .IN_CIN(IN_CIN), .IN_MODE(IN_MODE),
        .IN_CMD(IN_CMD), .IN_OPV(IN_OPV), .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .CE(CE), .MODE(MODE), .CMD(CMD), .VALID(VALID), .ALU_RES(ALU_RES),
        .ALU_FLAGS(ALU_FLAGS), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_RES(OUT_RES), .OUT_FLAGS(OUT_FLAGS), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    // ALU stand-in: result is only meaningful once CE has been held for the command latency
    always @(posedge clk) ce_cnt <= CE ? ce_cnt + 1 : 0;
    always_comb begin
        sum9  = {1'b0, OPA} + {1'b0, OPB};
        dif9  = {1'b0, OPA} - {1'b0, OPB};
        mres  = ({9'b0, OPA} + 17'd1) * ({9'b0, OPB} + 17'd1);
        lat   = (MODE && (CMD == 4'b1001 || CMD == 4'b1010)) ? 3 : 2;
        alu_r = 16'h0;
        cout  = 1'b0;
        ofl   = 1'b0;
        if (!MODE) alu_r = {8'h0, OPA & OPB};
        else case (CMD)
            4'b0000: begin alu_r = {7'h0, sum9}; cout = sum9[8]; end
            4'b1001: alu_r = mres[15:0];
            4'b1010: alu_r = {7'h0, OPA, 1'b0} * {8'h0, OPB};
            4'b1011: begin alu_r = {{8{sum9[7]}}, sum9[7:0]}; ofl = (OPA[7] == OPB[7]) && (sum9[7] != OPA[7]); end
            4'b1100: begin alu_r = {{8{dif9[7]}}, dif9[7:0]}; ofl = (OPA[7] != OPB[7]) && (dif9[7] != OPA[7]); end
            default: alu_r = 16'h0;
        endcase
        ALU_RES   = (ce_cnt >= lat) ? alu_r : 16'hDEAD;
        ALU_FLAGS = (ce_cnt >= lat) ? {cout, ofl, OPA > OPB, OPA == OPB, OPA < OPB, VALID != 2'b11} : 6'b101010;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [21:0] e;
        forever begin
            @(negedge clk);
            if (RST && OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h/%0h expected=none", OUT_RES, OUT_FLAGS);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_res", 64'(OUT_RES), 64'(e[21:6]));
                    chk("result_flags", 64'(OUT_FLAGS), 64'(e[5:0]));
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic m, input logic [3:0] c,
                        input logic [1:0] v, input logic expect_en, input logic [15:0] er, input logic [5:0] ef);
        int n = 0;
        IN_OPA = a; IN_OPB = b; IN_CIN = 1'b0; IN_MODE = m; IN_CMD = c; IN_OPV = v; IN_VALID = 1'b1;
        @(negedge clk);
        while (!IN_READY && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!IN_READY) begin
            IN_VALID = 1'b0;
            checks++;
            failures++;
            $display("FAIL push_timeout actual=IN_READY low expected=accept within 200 cycles");
            return;
        end
        if (expect_en) exp_q.push_back({er, ef});
        @(posedge clk);
        #1 IN_VALID = 1'b0;
    endtask

    task automatic timed(output int first_v, output int ce_n);
        first_v = 0;
        ce_n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (CE) ce_n++;
            if (OUT_VALID && first_v == 0) first_v = k;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(exp_q.size() != 0 || BUSY), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=still running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int fv, cn, n;
        logic [15:0] r;
        logic [5:0]  f;
        logic        ok;
        fork monitor(); join_none
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({OPA, OPB, CIN, CE, MODE, CMD, VALID, OUT_VALID, OUT_RES, OUT_FLAGS, BUSY}), 64'd0);
        chk("reset_in_ready", 64'(IN_READY), 64'd0);
        RST = 1'b1;
        @(posedge clk);
        #1;
        // 1: ADD 1+1, result after edge 4
        push(8'd1, 8'd1, 1'b1, 4'b0000, 2'b11, 1'b1, 16'd2, 6'b000100);
        timed(fv, cn);
        chk("add_valid_edge", 64'(fv), 64'd4);
        chk("add_ce_cycles", 64'(cn), 64'd3);
        chk("add_in_ready", 64'(IN_READY), 64'd1);
        chk("add_busy", 64'(BUSY), 64'd0);
        // 2: MUL_INC 255*255, result after edge 5, CE high 4 cycles
        push(8'd255, 8'd255, 1'b1, 4'b1001, 2'b11, 1'b1, 16'h0000, 6'b000100);
        timed(fv, cn);
        chk("mul_valid_edge", 64'(fv), 64'd5);
        chk("mul_ce_cycles", 64'(cn), 64'd4);
        // 3: five back-to-back pushes under back-pressure
        OUT_READY = 1'b0;
        push(8'd2,   8'd3,   1'b1, 4'b0000, 2'b11, 1'b1, 16'd5,    6'b000010);
        push(8'd10,  8'd20,  1'b1, 4'b0000, 2'b11, 1'b1, 16'd30,   6'b000010);
        push(8'd200, 8'd100, 1'b1, 4'b0000, 2'b11, 1'b1, 16'h012C, 6'b101000);
        push(8'd7,   8'd7,   1'b1, 4'b0000, 2'b11, 1'b1, 16'd14,   6'b000100);
        push(8'hF0,  8'h3C,  1'b0, 4'b0000, 2'b11, 1'b1, 16'h0030, 6'b001000);
        chk("full_in_ready", 64'(IN_READY), 64'd0);
        chk("full_busy", 64'(BUSY), 64'd1);
        OUT_READY = 1'b1;
        drain("burst_drain");
        // 4: long hold, then release
        OUT_READY = 1'b0;
        push(8'd3, 8'd4, 1'b1, 4'b1010, 2'b11, 1'b1, 16'd24, 6'b000010);
        push(8'd5, 8'd5, 1'b1, 4'b0000, 2'b11, 1'b1, 16'd10, 6'b000100);
        n = 0;
        while (!OUT_VALID && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_reached", 64'(OUT_VALID), 64'd1);
        r = OUT_RES;
        f = OUT_FLAGS;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (OUT_VALID !== 1'b1 || OUT_RES !== r || OUT_FLAGS !== f || CE !== 1'b0) ok = 1'b0;
        end
        chk("hold_stable", 64'(ok), 64'd1);
        chk("hold_res", 64'(r), 64'd24);
        OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        chk("release_idle", 64'({OUT_VALID, CE}), 64'd0);
        @(posedge clk);
        #1;
        chk("release_issue", 64'({CE, OPA}), 64'({1'b1, 8'd5}));
        drain("hold_drain");
        // 5: OPV=00 forwarded, ERR comes back from the ALU
        push(8'd1, 8'd1, 1'b1, 4'b0000, 2'b00, 1'b1, 16'd2, 6'b000101);
        n = 0;
        while (!CE && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("opv_ce", 64'(CE), 64'd1);
        chk("opv_forward", 64'(VALID), 64'd0);
        drain("opv_drain");
        // 6: reset during WAIT of SSUB with two ops queued
        push(8'h80, 8'd1, 1'b1, 4'b1100, 2'b11, 1'b0, 16'd0, 6'd0);
        push(8'd1,  8'd2, 1'b1, 4'b0000, 2'b11, 1'b0, 16'd0, 6'd0);
        push(8'd3,  8'd4, 1'b1, 4'b0000, 2'b11, 1'b0, 16'd0, 6'd0);
        chk("pre_rst_ce", 64'({CE, CMD}), 64'({1'b1, 4'b1100}));
        RST = 1'b0;
        #1;
        chk("rst_in_ready", 64'(IN_READY), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_outputs", 64'({OPA, OPB, CIN, CE, MODE, CMD, VALID, OUT_VALID, OUT_RES, OUT_FLAGS, BUSY}), 64'd0);
        @(posedge clk);
        #1;
        RST = 1'b1;
        ok = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (OUT_VALID || CE || BUSY) ok = 1'b1;
        end
        chk("post_rst_quiet", 64'(ok), 64'd0);
        push(8'd127, 8'd1, 1'b1, 4'b1011, 2'b11, 1'b1, 16'hFF80, 6'b011000);
        drain("sadd_drain");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
